// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, fault cause codes and
// default widths used by the top level and its timeout counter.
package load_store_unit_pkg;

    // Default data/address width in bits.
    localparam int XLEN_DEFAULT = 64;

    // Width of the memory wait counter; holds TIMEOUT values up to 255.
    localparam int WAIT_CNT_W = 8;

    // Access sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        RESP  = 2'b10,
        FAULT = 2'b11
    } lsu_state_e;

    // faultCause encodings (00 is reported whenever fault is low).
    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_BOTH_EN    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

    // A doubleword access must sit on an 8-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] low_bits);
        return low_bits != 3'b000;
    endfunction

endpackage

// File: rtl/lsu_timeout_counter.sv
// Counts consecutive cycles spent waiting for a memory acknowledge and flags
// the cycle in which the LIMIT-th wait cycle is reached.
module lsu_timeout_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    // count holds the number of wait cycles already completed, so the current
    // cycle is the LIMIT-th one when count equals LIMIT-1.
    assign expired = enable && (count == LAST);

    // Advance once per enabled cycle; clear takes priority and the count
    // stops at the expiry point since the caller leaves the wait state there.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding doubleword load/store unit. Accepts one ld or sd at a
// time, performs the memory handshake with a bounded wait, and reports the
// outcome as a write-back, completion or fault pulse.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            loadEn,
    input  logic            storeEn,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] storeData,
    input  logic [4:0]      rdIn,
    output logic            busy,
    output logic            memReq,
    output logic            memWe,
    output logic [XLEN-1:0] memAddr,
    output logic [XLEN-1:0] memWdata,
    input  logic            memAck,
    input  logic [XLEN-1:0] memRdata,
    output logic            wbValid,
    output logic [4:0]      wbRd,
    output logic [XLEN-1:0] wbData,
    output logic            done,
    output logic            fault,
    output logic [1:0]      faultCause
);

    lsu_state_e state;
    logic       op_load;   // latched operation: 1 = ld, 0 = sd
    logic [4:0] rd_q;      // latched destination register
    logic       wait_expired;

    // The wait counter runs only while a request is outstanding and restarts
    // from zero on every entry into REQ.
    lsu_timeout_counter #(
        .WIDTH (WAIT_CNT_W),
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != REQ),
        .enable  (state == REQ),
        .expired (wait_expired)
    );

    // Access FSM with every output registered; issue inputs are only looked
    // at in IDLE and memAck only in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_load    <= 1'b0;
            rd_q       <= '0;
            busy       <= 1'b0;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            wbValid    <= 1'b0;
            wbRd       <= '0;
            wbData     <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
            faultCause <= CAUSE_NONE;
        end else begin
            // NOTE: pulse outputs default low here so each branch only has to
            // raise them for the single cycle they are meant to be seen.
            wbValid    <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            faultCause <= CAUSE_NONE;

            case (state)
                IDLE: begin
                    if (loadEn && storeEn) begin
                        state      <= FAULT;
                        busy       <= 1'b1;
                        fault      <= 1'b1;
                        faultCause <= CAUSE_BOTH_EN;
                    end else if (loadEn ^ storeEn) begin
                        op_load <= loadEn;
                        rd_q    <= rdIn;
                        busy    <= 1'b1;
                        if (is_misaligned(addr[2:0])) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            faultCause <= CAUSE_MISALIGNED;
                        end else begin
                            state    <= REQ;
                            memReq   <= 1'b1;
                            memWe    <= storeEn;
                            memAddr  <= addr;
                            memWdata <= storeData;
                        end
                    end
                end

                REQ: begin
                    if (memAck) begin
                        state  <= RESP;
                        memReq <= 1'b0;
                        if (op_load) begin
                            wbValid <= 1'b1;
                            wbRd    <= rd_q;
                            wbData  <= memRdata;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (wait_expired) begin
                        state      <= FAULT;
                        memReq     <= 1'b0;
                        fault      <= 1'b1;
                        faultCause <= CAUSE_TIMEOUT;
                    end
                end

                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    memWe <= 1'b0;
                end

                FAULT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    memWe <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    memReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scenario bench for load_store_unit: expected completions are queued when an
// access is issued and checked when the unit raises wbValid, done or fault.
module tb_load_store_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            loadEn, storeEn;
    logic [XLEN-1:0] addr, storeData;
    logic [4:0]      rdIn;
    logic            busy, memReq, memWe;
    logic [XLEN-1:0] memAddr, memWdata;
    logic            memAck;
    logic [XLEN-1:0] memRdata;
    logic            wbValid;
    logic [4:0]      wbRd;
    logic [XLEN-1:0] wbData;
    logic            done, fault;
    logic [1:0]      faultCause;

    // Expected completion: pulses = {wbValid, done, fault}.
    typedef struct {
        logic [2:0]      pulses;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [1:0]      cause;
    } result_t;

    result_t sb[$];
    int      checks = 0;
    int      errors = 0;

    load_store_unit #(
        .XLEN    (XLEN),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .loadEn     (loadEn),
        .storeEn    (storeEn),
        .addr       (addr),
        .storeData  (storeData),
        .rdIn       (rdIn),
        .busy       (busy),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWdata   (memWdata),
        .memAck     (memAck),
        .memRdata   (memRdata),
        .wbValid    (wbValid),
        .wbRd       (wbRd),
        .wbData     (wbData),
        .done       (done),
        .fault      (fault),
        .faultCause (faultCause)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push_result(input logic [2:0] p, input logic [4:0] rd,
                               input logic [XLEN-1:0] d, input logic [1:0] c);
        result_t r;
        r.pulses = p; r.rd = rd; r.data = d; r.cause = c;
        sb.push_back(r);
    endtask

    // Drive one issue cycle; returns at the negedge of the cycle after issue.
    task automatic issue(input logic ld, input logic st, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] d, input logic [4:0] rd);
        @(negedge clk);
        loadEn = ld; storeEn = st; addr = a; storeData = d; rdIn = rd;
        @(negedge clk);
        loadEn = 1'b0; storeEn = 1'b0;
    endtask

    // Wait (bounded) for a completion pulse, then pop and compare.
    task automatic wait_result(input int budget, input int exp_lat);
        int      lat;
        result_t exp;
        lat = 0;
        while (!(wbValid || done || fault) && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!(wbValid || done || fault)) begin
            errors++;
            $display("FAIL result_timeout: no pulse after %0d cycles, queue %0d", lat, sb.size());
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL result_latency: got %0d extra cycles, want %0d", lat, exp_lat);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got {wb,done,fault}=%b with empty queue", {wbValid, done, fault});
            return;
        end
        exp = sb.pop_front();
        if ({wbValid, done, fault} !== exp.pulses) begin
            errors++;
            $display("FAIL result_kind: got %b want %b", {wbValid, done, fault}, exp.pulses);
        end
        if (exp.pulses[2]) begin
            checks++;
            if (wbRd !== exp.rd || wbData !== exp.data) begin
                errors++;
                $display("FAIL wb_value: got rd=%0d data=%h want rd=%0d data=%h", wbRd, wbData, exp.rd, exp.data);
            end
        end
        if (exp.pulses[0]) begin
            checks++;
            if (faultCause !== exp.cause) begin
                errors++;
                $display("FAIL fault_cause: got %b want %b", faultCause, exp.cause);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        loadEn = 0; storeEn = 0; addr = '0; storeData = '0; rdIn = '0;
        memAck = 0; memRdata = '0;
        @(negedge clk);
        checks++;
        if ({busy, memReq, memWe, wbValid, done, fault, faultCause} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000", {busy, memReq, memWe, wbValid, done, fault, faultCause});
        end
        checks++;
        if ({memAddr, memWdata, wbData, wbRd} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h wb=%h rd=%0d want all 0", memAddr, memWdata, wbData, wbRd);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_wait();
        push_result(3'b100, 5'd5, 64'hDEADBEEF_CAFEF00D, 2'b00);
        issue(1, 0, 64'h100, 64'h0, 5'd5);
        // cycle N+1
        checks++;
        if ({memReq, memWe, busy} !== 3'b101 || memAddr !== 64'h100) begin
            errors++;
            $display("FAIL ld_req: got req/we/busy=%b addr=%h want 101 addr=100", {memReq, memWe, busy}, memAddr);
        end
        // cycle N+2: a store issued while busy must be ignored
        @(negedge clk);
        storeEn = 1; addr = 64'h300; storeData = 64'h55;
        checks++;
        if (memReq !== 1'b1 || memAddr !== 64'h100) begin
            errors++;
            $display("FAIL ld_hold1: got req=%b addr=%h want 1 addr=100", memReq, memAddr);
        end
        // cycle N+3
        @(negedge clk);
        storeEn = 0;
        checks++;
        if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 64'h100) begin
            errors++;
            $display("FAIL ld_hold2: got req=%b we=%b addr=%h want 1 0 100", memReq, memWe, memAddr);
        end
        // cycle N+4: ack after three wait cycles
        @(negedge clk);
        checks++;
        if (memReq !== 1'b1) begin
            errors++;
            $display("FAIL ld_hold3: got req=%b want 1", memReq);
        end
        memAck = 1; memRdata = 64'hDEADBEEF_CAFEF00D;
        // cycle N+5: write-back
        @(negedge clk);
        memAck = 0; memRdata = 64'h0;
        wait_result(6, 0);
        @(negedge clk);
        checks++;
        if ({wbValid, busy, memReq} !== 3'b000 || wbData !== 64'hDEADBEEF_CAFEF00D || wbRd !== 5'd5) begin
            errors++;
            $display("FAIL ld_after: got wb/busy/req=%b data=%h rd=%0d want 000 data held", {wbValid, busy, memReq}, wbData, wbRd);
        end
    endtask

    task automatic test_store_zero_wait();
        push_result(3'b010, 5'd0, 64'h0, 2'b00);
        issue(0, 1, 64'h208, 64'h1234, 5'd9);
        checks++;
        if ({memReq, memWe} !== 2'b11 || memAddr !== 64'h208 || memWdata !== 64'h1234) begin
            errors++;
            $display("FAIL sd_req: got req/we=%b addr=%h wdata=%h want 11 208 1234", {memReq, memWe}, memAddr, memWdata);
        end
        memAck = 1;
        @(negedge clk);
        memAck = 0;
        wait_result(6, 0);
        checks++;
        if (memReq !== 1'b0 || wbRd !== 5'd5 || wbData !== 64'hDEADBEEF_CAFEF00D) begin
            errors++;
            $display("FAIL sd_wb_hold: got req=%b rd=%0d data=%h want 0 5 deadbeefcafef00d", memReq, wbRd, wbData);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL sd_pulse: got done/busy=%b want 00", {done, busy});
        end
    endtask

    task automatic test_misaligned();
        push_result(3'b001, 5'd0, 64'h0, 2'b01);
        issue(1, 0, 64'h104, 64'h0, 5'd3);
        checks++;
        if (memReq !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mis_req: got req=%b busy=%b want 0 1", memReq, busy);
        end
        wait_result(6, 0);
        @(negedge clk);
        checks++;
        if ({fault, faultCause, busy, memReq} !== 5'b0) begin
            errors++;
            $display("FAIL mis_after: got fault/cause/busy/req=%b want 00000", {fault, faultCause, busy, memReq});
        end
    endtask

    task automatic test_both_enables();
        push_result(3'b001, 5'd0, 64'h0, 2'b10);
        issue(1, 1, 64'h400, 64'h0, 5'd4);
        // second issue while busy (FAULT cycle) must be ignored
        loadEn = 1; addr = 64'h500;
        wait_result(6, 0);
        @(negedge clk);
        loadEn = 0;
        checks++;
        if ({busy, memReq, fault} !== 3'b000) begin
            errors++;
            $display("FAIL both_after: got busy/req/fault=%b want 000", {busy, memReq, fault});
        end
        @(negedge clk);
        checks++;
        if ({busy, memReq} !== 2'b00) begin
            errors++;
            $display("FAIL both_ignored: got busy/req=%b want 00", {busy, memReq});
        end
    endtask

    task automatic test_timeout();
        int req_cycles;
        push_result(3'b001, 5'd0, 64'h0, 2'b11);
        issue(1, 0, 64'h40, 64'h0, 5'd2);
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (fault) break;
            if (memReq) req_cycles++;
            @(negedge clk);
        end
        checks++;
        if (req_cycles != 4) begin
            errors++;
            $display("FAIL to_req_cycles: got %0d want 4", req_cycles);
        end
        checks++;
        if (memReq !== 1'b0) begin
            errors++;
            $display("FAIL to_req_drop: got req=%b want 0", memReq);
        end
        wait_result(2, 0);
        @(negedge clk);
        checks++;
        if ({busy, fault, memReq} !== 3'b000) begin
            errors++;
            $display("FAIL to_idle: got busy/fault/req=%b want 000", {busy, fault, memReq});
        end
    endtask

    task automatic test_reset_in_req();
        issue(1, 0, 64'h80, 64'h0, 5'd6);
        checks++;
        if (memReq !== 1'b1) begin
            errors++;
            $display("FAIL rr_pre: got req=%b want 1", memReq);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({memReq, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rr_abort: got req/busy=%b want 00", {memReq, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        // memAck outside REQ must have no effect
        memAck = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({wbValid, done, fault, memReq, busy} !== 5'b0) begin
                errors++;
                $display("FAIL rr_quiet: cycle %0d got wb/done/fault/req/busy=%b want 00000", i, {wbValid, done, fault, memReq, busy});
            end
        end
        memAck = 0;
        push_result(3'b100, 5'd7, 64'h0123_4567_89AB_CDEF, 2'b00);
        issue(1, 0, 64'h180, 64'h0, 5'd7);
        memAck = 1; memRdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        memAck = 0; memRdata = 64'h0;
        wait_result(6, 0);
    endtask

    initial begin
        test_reset();
        test_load_wait();
        test_store_zero_wait();
        test_misaligned();
        test_both_enables();
        test_timeout();
        test_reset_in_req();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0 || {wbValid, done, fault} !== 3'b000) begin
            errors++;
            $display("FAIL final_queue: got %0d pending, pulses=%b want 0 pending", sb.size(), {wbValid, done, fault});
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
